line_clock_ctl: RTL

Parametrised line-clock controller for the processor board: the next generation of the board's fixed 50 Hz timer and timer-enable button logic. It generates a programmable-rate tick and debounces a front-panel enable button that toggles a status LED. It also exposes a KW11-L-compatible CSR on a Wishbone slave port and raises either a vectored interrupt with istb/iack handshake or a legacy fixed-line request. It sits beside the CPU on the board's local bus; address decoding of the CSR (177546 by default) is external.

---
 rtl/line_clock_ctl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/line_clock_ctl.sv
// Line-clock controller: programmable tick, debounced enable button,
// KW11-L style CSR on Wishbone, vectored or fixed-line interrupt.
module line_clock_ctl #(
    parameter int          CLK_HZ      = 100000000,
    parameter int          TICK_HZ     = 50,
    parameter int          DEBOUNCE    = 2,
    parameter logic [15:0] VECTOR      = 16'o000100,
    parameter bit          INIT_ENABLE = 1'b1,
    parameter bit          LEGACY      = 1'b0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_sel_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        button_i,
    output logic        status_o,
    output logic        tick_o,
    output logic        irq_o,
    output logic [15:0] ivec_o,
    input  logic        istb_i,
    output logic        iack_o
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0]       cnt;
    logic                raw_tick;
    logic [1:0]          sync_q;
    logic                btn;
    logic [DEBOUNCE-1:0] shreg;
    logic [DEBOUNCE:0]   sh_cat;
    logic                armed;
    logic                status;
    logic                mon;
    logic                ie;
    logic                pend;
    logic                iack_q;
    logic                bus_sel;
    logic                wr_lo;
    logic                iack_rise;
    logic                unused_bits;

    assign btn       = sync_q[1];
    assign sh_cat    = {shreg, btn};
    assign bus_sel   = wb_cyc_i & wb_stb_i;
    assign wr_lo     = bus_sel & wb_we_i & ~wb_ack_o & wb_sel_i[0];
    assign iack_rise = istb_i & pend & ~iack_q;

    assign status_o = status;
    assign tick_o   = raw_tick & status;
    assign irq_o    = LEGACY ? tick_o : pend;
    assign iack_o   = iack_q;
    assign wb_dat_o = wb_ack_o ? {8'h00, mon, ie, 6'b0} : 16'h0000;

    assign ivec_o = (!LEGACY && istb_i && (pend || iack_q))
                  ? VECTOR : 16'h0000;

    assign unused_bits = ^{wb_dat_i[15:8], wb_dat_i[5:0], wb_sel_i[1]};

    // Free-running divider; raw_tick is registered so it lands
    // exactly DIV cycles after reset release.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt      <= '0;
            raw_tick <= 1'b0;
        end else begin
            raw_tick <= (cnt == TERM);
            cnt      <= (cnt == TERM) ? '0 : cnt + CW'(1);
        end
    end

    // Button is judged on the history before this tick's sample,
    // so a hold spanning DEBOUNCE+1 ticks is needed to toggle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync_q <= 2'b00;
            shreg  <= '0;
            armed  <= 1'b1;
            status <= INIT_ENABLE;
        end else begin
            sync_q <= {sync_q[0], button_i};
            if (raw_tick) begin
                shreg <= sh_cat[DEBOUNCE-1:0];
                if (&shreg && armed) begin
                    status <= ~status;
                    armed  <= 1'b0;
                end else if (~|shreg) begin
                    armed <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            mon      <= 1'b0;
            ie       <= 1'b0;
        end else begin
            wb_ack_o <= bus_sel;
            if (tick_o) begin
                mon <= 1'b1;
            end else if (wr_lo) begin
                mon <= mon & wb_dat_i[7];
            end
            if (wr_lo) begin
                ie <= wb_dat_i[6];
            end
        end
    end

    // IE-clearing write beats a tick, which beats the acknowledge.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            pend   <= 1'b0;
            iack_q <= 1'b0;
        end else if (LEGACY) begin
            pend   <= 1'b0;
            iack_q <= 1'b0;
        end else begin
            iack_q <= istb_i & (iack_q | pend);
            if (wr_lo && !wb_dat_i[6]) begin
                pend <= 1'b0;
            end else if (tick_o && ie) begin
                pend <= 1'b1;
            end else if (iack_rise) begin
                pend <= 1'b0;
            end
        end
    end

endmodule
